// File: rtl/sdram_host_pkg.sv
// Shared types and constants for the SDRAM host-port arbiter.
package sdram_host_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 24;
  localparam int unsigned DATA_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StIssue  = 2'd1,
    StBusy   = 2'd2,
    StRdWait = 2'd3
  } state_e;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant with a registered pointer that flips away from the last winner.
module rr_arbiter2
  import sdram_host_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o
);

  logic ptr_q, ptr_d;

  // Grant selection: pointer breaks ties, a lone requester always wins.
  always_comb begin
    gnt_valid_o = |req_i;
    if (req_i[P0] && req_i[P1]) begin
      gnt_idx_o = ptr_q;
    end else if (req_i[P1]) begin
      gnt_idx_o = P1;
    end else begin
      gnt_idx_o = P0;
    end
    ptr_d = ptr_q;
    if (advance_i && gnt_valid_o) begin
      ptr_d = ~gnt_idx_o;
    end
  end

  // Pointer register; favours port 0 out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= P0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/sdram_host_arbiter.sv
// Serialises two requesters onto the single sdram_controller host port and routes read data back.
module sdram_host_arbiter
  import sdram_host_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_valid_i,
  input  logic                  p0_we_i,
  input  logic [ADDR_WIDTH-1:0] p0_addr_i,
  input  logic [DATA_WIDTH-1:0] p0_wdata_i,
  output logic                  p0_ready_o,
  output logic                  p0_rvalid_o,
  output logic [DATA_WIDTH-1:0] p0_rdata_o,
  input  logic                  p1_valid_i,
  input  logic                  p1_we_i,
  input  logic [ADDR_WIDTH-1:0] p1_addr_i,
  input  logic [DATA_WIDTH-1:0] p1_wdata_i,
  output logic                  p1_ready_o,
  output logic                  p1_rvalid_o,
  output logic [DATA_WIDTH-1:0] p1_rdata_o,
  output logic [ADDR_WIDTH-1:0] ctl_addr_o,
  output logic [DATA_WIDTH-1:0] ctl_wr_data_o,
  output logic                  ctl_wr_enable_o,
  output logic                  ctl_rd_enable_o,
  input  logic                  ctl_busy_i,
  input  logic                  ctl_rd_ready_i,
  input  logic [DATA_WIDTH-1:0] ctl_rd_data_i,
  output logic                  timeout_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  state_e                          state_q, state_d;
  logic                            owner_q, owner_d;
  logic                            we_q, we_d;
  logic [ADDR_WIDTH-1:0]           addr_q, addr_d;
  logic [DATA_WIDTH-1:0]           wdata_q, wdata_d;
  logic [CntW-1:0]                 cnt_q, cnt_d;
  logic                            rd_done_q, rd_done_d;
  logic                            timeout_q, timeout_d;
  logic                            wr_en_q, wr_en_d;
  logic                            rd_en_q, rd_en_d;
  logic [1:0]                      ready_q, ready_d;
  logic [1:0]                      rvalid_q, rvalid_d;
  logic [1:0][DATA_WIDTH-1:0]      rdata_q, rdata_d;

  logic gnt_valid, gnt_idx, grant, rd_cap;

  assign grant = (state_q == StIdle) && !ctl_busy_i && gnt_valid;

  rr_arbiter2 u_rr (
    .clk         (clk),
    .rst         (rst),
    .req_i       ({p1_valid_i, p0_valid_i}),
    .advance_i   (grant),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  // Next-state, command latching and read-data routing.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    rd_done_d = rd_done_q;
    timeout_d = timeout_q;
    rdata_d   = rdata_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    ready_d   = 2'b00;
    rvalid_d  = 2'b00;

    // Only the first rd_ready of an outstanding read is taken.
    rd_cap = (state_q != StIdle) && !we_q && !rd_done_q && ctl_rd_ready_i;
    if (rd_cap) begin
      rdata_d[owner_q]  = ctl_rd_data_i;
      rvalid_d[owner_q] = 1'b1;
      rd_done_d         = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (grant) begin
          owner_d          = gnt_idx;
          we_d             = gnt_idx ? p1_we_i : p0_we_i;
          addr_d           = gnt_idx ? p1_addr_i : p0_addr_i;
          wdata_d          = gnt_idx ? p1_wdata_i : p0_wdata_i;
          wr_en_d          = we_d;
          rd_en_d          = !we_d;
          ready_d[gnt_idx] = 1'b1;
          cnt_d            = '0;
          rd_done_d        = 1'b0;
          state_d          = StIssue;
        end
      end
      StIssue: begin
        if (ctl_busy_i) begin
          state_d = StBusy;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StBusy: begin
        if (!ctl_busy_i) begin
          state_d = (we_q || rd_done_q || rd_cap) ? StIdle : StRdWait;
        end
      end
      StRdWait: begin
        if (ctl_rd_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; everything clears on rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      owner_q   <= P0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      rd_done_q <= 1'b0;
      timeout_q <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      ready_q   <= 2'b00;
      rvalid_q  <= 2'b00;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      rd_done_q <= rd_done_d;
      timeout_q <= timeout_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      ready_q   <= ready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  assign p0_ready_o      = ready_q[P0];
  assign p1_ready_o      = ready_q[P1];
  assign p0_rvalid_o     = rvalid_q[P0];
  assign p1_rvalid_o     = rvalid_q[P1];
  assign p0_rdata_o      = rdata_q[P0];
  assign p1_rdata_o      = rdata_q[P1];
  assign ctl_addr_o      = addr_q;
  assign ctl_wr_data_o   = wdata_q;
  assign ctl_wr_enable_o = wr_en_q;
  assign ctl_rd_enable_o = rd_en_q;
  assign timeout_o       = timeout_q;

endmodule
